// File: rtl/perceptron_pkg.sv
// perceptron_pkg: scheduler state encoding, Q5.27 format constants and default layer geometry
package perceptron_pkg;
    typedef enum logic [2:0] {IDLE, BIAS, START, STREAM, WAIT_DONE, WRITE, FIN} sched_state_t;
    localparam int Q_INT_W = 5;
    localparam int Q_FRAC_W = 27;
    localparam int Q_W = Q_INT_W + Q_FRAC_W;
    localparam int DEF_INPUT_SIZE = 784;
    localparam int DEF_NUM_NEURONS = 16;
endpackage

// File: rtl/layer_scheduler_if.sv
// layer_scheduler_if: scheduler <-> perceptron core link (bank select, bias, start, activation stream, result)
interface layer_scheduler_if
    import perceptron_pkg::*;
#(
    parameter int DATA_W = Q_W,
    parameter int NEURON_W = 4
);
    logic [NEURON_W-1:0] sel;
    logic [DATA_W-1:0]   bias;
    logic                start;
    logic [DATA_W-1:0]   x_tdata;
    logic                x_tvalid;
    logic                x_tready;
    logic                done;
    logic [DATA_W-1:0]   a_tdata;
    modport master (output sel, bias, start, x_tdata, x_tvalid, input x_tready, done, a_tdata);
    modport slave (input sel, bias, start, x_tdata, x_tvalid, output x_tready, done, a_tdata);
endinterface

// File: rtl/x_skid_fifo.sv
// x_skid_fifo: 2-entry valid/ready buffer; the head holds still until it is popped
module x_skid_fifo
    import perceptron_pkg::*;
#(
    parameter int DATA_W = Q_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop_ready,
    output logic [DATA_W-1:0] head,
    output logic              valid,
    output logic [1:0]        occ
);
    logic [DATA_W-1:0] mem [2];
    logic rptr, wptr, pop;
    assign valid = occ != 2'd0;
    assign pop = valid && pop_ready;
    assign head = mem[rptr];
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rptr <= 1'b0;
            wptr <= 1'b0;
            occ <= 2'd0;
        end else begin
            if (push) begin
                mem[wptr] <= push_data;
                wptr <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
endmodule

// File: rtl/layer_scheduler.sv
// layer_scheduler: runs one perceptron core over every neuron of a layer
// (bias fetch, start pulse, input stream, result wait, output write).
module layer_scheduler
    import perceptron_pkg::*;
#(
    parameter int INPUT_SIZE = DEF_INPUT_SIZE,
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int DATA_W = Q_W,
    parameter int ADDR_W = 10,
    parameter int NEURON_W = 4,
    parameter int DONE_TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ADDR_W-1:0]   in_rd_addr,
    output logic                in_rd_en,
    input  logic [DATA_W-1:0]   in_rd_data,
    output logic [NEURON_W-1:0] bias_rd_addr,
    input  logic [DATA_W-1:0]   bias_rd_data,
    layer_scheduler_if.master   pe,
    output logic                out_wr_en,
    output logic [NEURON_W-1:0] out_wr_addr,
    output logic [DATA_W-1:0]   out_wr_data
);
    localparam int CNT_W = ADDR_W + 1;
    localparam int WAIT_W = $clog2(DONE_TIMEOUT + 1);
    localparam logic [NEURON_W-1:0] LAST_N = NEURON_W'(NUM_NEURONS - 1);
    localparam logic [CNT_W-1:0] N_BEATS = CNT_W'(INPUT_SIZE);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(INPUT_SIZE - 1);
    localparam logic [WAIT_W-1:0] TIMEOUT = WAIT_W'(DONE_TIMEOUT);

    sched_state_t state, state_n;
    logic [NEURON_W-1:0] n;
    logic [CNT_W-1:0] rd_cnt, tx_cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [DATA_W-1:0] result;
    logic [1:0] occ;
    logic rd_pending, done_armed, hs, last_hs, accept, timeout, room;

    x_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
        .clk(clk),
        .rst(rst),
        .push(rd_pending),
        .push_data(in_rd_data),
        .pop_ready(pe.x_tready),
        .head(pe.x_tdata),
        .valid(pe.x_tvalid),
        .occ(occ)
    );

    // Credit counts the beat leaving this cycle so a steady ready stream never bubbles.
    assign room = ({1'b0, occ} + {2'b0, rd_pending} - {2'b0, hs}) < 3'd2;
    assign hs = pe.x_tvalid && pe.x_tready;
    assign last_hs = hs && tx_cnt == LAST_BEAT;
    assign accept = state == WAIT_DONE && done_armed && pe.done;
    assign timeout = state == WAIT_DONE && wait_cnt == TIMEOUT;
    assign in_rd_en = (state == START || state == STREAM) && rd_cnt != N_BEATS && room;
    assign in_rd_addr = in_rd_en ? rd_cnt[ADDR_W-1:0] : '0;
    assign busy = state != IDLE;
    assign done = state == FIN;
    assign bias_rd_addr = state == BIAS ? n : '0;
    assign pe.start = state == START;
    assign out_wr_en = state == WRITE;
    assign out_wr_addr = out_wr_en ? n : '0;
    assign out_wr_data = out_wr_en ? result : '0;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:      state_n = start ? BIAS : IDLE;
            BIAS:      state_n = START;
            START:     state_n = STREAM;
            STREAM:    state_n = last_hs ? WAIT_DONE : STREAM;
            WAIT_DONE: state_n = accept ? WRITE : timeout ? FIN : WAIT_DONE;
            WRITE:     state_n = n == LAST_N ? FIN : BIAS;
            FIN:       state_n = IDLE;
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state <= IDLE;
            n <= '0;
            rd_cnt <= '0;
            tx_cnt <= '0;
            wait_cnt <= '0;
            result <= '0;
            rd_pending <= 1'b0;
            done_armed <= 1'b0;
            err <= 1'b0;
            pe.sel <= '0;
            pe.bias <= '0;
        end else begin
            state <= state_n;
            rd_pending <= in_rd_en;
            if (state == IDLE && start) begin
                n <= '0;
                err <= 1'b0;
            end
            if (state == WRITE && n != LAST_N) n <= n + 1'b1;
            if (timeout && !accept) err <= 1'b1;
            if (state == BIAS) begin
                pe.sel <= n;
                rd_cnt <= '0;
                tx_cnt <= '0;
            end
            if (state == START) pe.bias <= bias_rd_data;
            if (in_rd_en) rd_cnt <= rd_cnt + 1'b1;
            if (hs) tx_cnt <= tx_cnt + 1'b1;
            // A done level still high from the previous neuron only counts after it has dropped.
            done_armed <= state == START ? 1'b0 : (done_armed || !pe.done);
            wait_cnt <= state == WAIT_DONE ? wait_cnt + 1'b1 : '0;
            if (accept) result <= pe.a_tdata;
        end
endmodule
